// File: rtl/ysyx_25050148_csr_ctrl_pkg.sv
// Shared encodings for the CSR sequencer: op codes, machine CSR addresses,
// sequencer states and the latched request record.
package ysyx_25050148_csr_ctrl_pkg;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_NONE    = 12'h000;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] csr;
    logic [31:0] src;
    logic        src_x0;
    logic [31:0] pc;
  } csr_req_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return op > OP_MRET;
  endfunction

endpackage

// File: rtl/ysyx_25050148_csr_ctrl_if.sv
// Request/response, redirect and CSR-file bus between the sequencer (master)
// and its surroundings (slave: decode/execute, fetch and the CSR file).
interface ysyx_25050148_csr_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr;
  logic [31:0] req_src;
  logic        req_src_x0;
  logic [31:0] req_pc;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr1;
  logic [31:0] csr_wdata1;
  logic [11:0] csr_waddr2;
  logic [31:0] csr_wdata2;
  logic        resp_valid;
  logic [31:0] resp_rd_data;
  logic        resp_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    input  req_valid, req_op, req_csr, req_src, req_src_x0, req_pc, csr_rdata,
    output req_ready, csr_raddr, csr_wen, csr_waddr1, csr_wdata1, csr_waddr2,
           csr_wdata2, resp_valid, resp_rd_data, resp_illegal, redirect_valid,
           redirect_pc
  );

  modport slave (
    output req_valid, req_op, req_csr, req_src, req_src_x0, req_pc, csr_rdata,
    input  req_ready, csr_raddr, csr_wen, csr_waddr1, csr_wdata1, csr_waddr2,
           csr_wdata2, resp_valid, resp_rd_data, resp_illegal, redirect_valid,
           redirect_pc
  );
endinterface

// File: rtl/ysyx_25050148_csr_alu.sv
// Read-modify-write data path for CSRRW/CSRRS/CSRRC.
module ysyx_25050148_csr_alu
  import ysyx_25050148_csr_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  output logic [31:0] wdata
);

  always_comb begin
    wdata = src;
    case (op)
      OP_CSRRS: wdata = old_val | src;
      OP_CSRRC: wdata = old_val & ~src;
      default:  wdata = src;
    endcase
  end

endmodule

// File: rtl/ysyx_25050148_csr_ctrl.sv
// CSR sequencer: IDLE -> READ -> WRITE -> RESP for CSRRW/S/C, ECALL and MRET.
// Define YSYX_25050148_CSR_ILLEGAL_TRAP_EN to turn illegal ops into a trap.
module ysyx_25050148_csr_ctrl
  import ysyx_25050148_csr_ctrl_pkg::*;
#(
  parameter logic [31:0] MCAUSE_ECALL   = 32'd11,
  parameter logic [31:0] MCAUSE_ILLEGAL = 32'd2
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25050148_csr_ctrl_if.master    bus
);

`ifdef YSYX_25050148_CSR_ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP = 1'b1;
`else
  localparam bit ILL_TRAP = 1'b0;
`endif

  state_e      state_q, state_d;
  csr_req_t    req_q;
  logic [31:0] old_q;
  logic [31:0] alu_wdata;
  logic        ill, trap, mret, csr_op;

  assign ill    = is_illegal(req_q.op);
  assign trap   = (req_q.op == OP_ECALL) || (ILL_TRAP && ill);
  assign mret   = (req_q.op == OP_MRET);
  assign csr_op = (req_q.op == OP_CSRRW) || (req_q.op == OP_CSRRS) ||
                  (req_q.op == OP_CSRRC);

  ysyx_25050148_csr_alu u_alu (
    .op      (req_q.op),
    .old_val (old_q),
    .src     (req_q.src),
    .wdata   (alu_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.req_valid)
        req_q <= '{op: bus.req_op, csr: bus.req_csr, src: bus.req_src,
                   src_x0: bus.req_src_x0, pc: bus.req_pc};
      // A flagged-only illegal op reports zero rather than whatever the file returns.
      if (state_q == S_READ)
        old_q <= (ill && !ILL_TRAP) ? '0 : bus.csr_rdata;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.req_ready      = 1'b0;
    bus.csr_raddr      = CSR_NONE;
    bus.csr_wen        = 1'b0;
    bus.csr_waddr1     = CSR_NONE;
    bus.csr_wdata1     = '0;
    bus.csr_waddr2     = CSR_NONE;
    bus.csr_wdata2     = '0;
    bus.resp_valid     = 1'b0;
    bus.resp_rd_data   = '0;
    bus.resp_illegal   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_READ;
      end
      S_READ: begin
        if (trap)        bus.csr_raddr = CSR_MTVEC;
        else if (mret)   bus.csr_raddr = CSR_MEPC;
        else if (csr_op) bus.csr_raddr = req_q.csr;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (trap) begin
          bus.csr_wen    = 1'b1;
          bus.csr_waddr1 = CSR_MEPC;
          bus.csr_wdata1 = req_q.pc;
          bus.csr_waddr2 = CSR_MCAUSE;
          bus.csr_wdata2 = ill ? MCAUSE_ILLEGAL : MCAUSE_ECALL;
        end else if (csr_op) begin
          // Set/clear with rs1=x0 must not write (read-only CSRs stay untouched).
          bus.csr_wen    = (req_q.op == OP_CSRRW) || !req_q.src_x0;
          bus.csr_waddr1 = req_q.csr;
          bus.csr_wdata1 = alu_wdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid     = 1'b1;
        bus.resp_rd_data   = old_q;
        bus.resp_illegal   = ill;
        bus.redirect_valid = trap || mret;
        bus.redirect_pc    = (trap || mret) ? old_q : '0;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25050148_csr_ctrl.sv
// Directed vector bench for the CSR sequencer plus reset/ignore corner cases.
module tb_ysyx_25050148_csr_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  ysyx_25050148_csr_ctrl_if bif ();

  ysyx_25050148_csr_ctrl #(.MCAUSE_ECALL(32'd11), .MCAUSE_ILLEGAL(32'd2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [11:0] csr;
    logic [31:0] src;
    logic        x0;
    logic [31:0] pc;
    logic [31:0] rdata;
    bit          chk_ra;
    logic [11:0] ra;
    logic        wen;
    logic [11:0] wa1;
    logic [31:0] wd1;
    logic [11:0] wa2;
    logic [31:0] wd2;
    logic [31:0] rd;
    logic        ill;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic [11:0] csr,
                     input logic [31:0] src, input logic x0, input logic [31:0] pc,
                     input logic [31:0] rdata, input bit chk_ra, input logic [11:0] ra,
                     input logic wen, input logic [11:0] wa1, input logic [31:0] wd1,
                     input logic [11:0] wa2, input logic [31:0] wd2, input logic [31:0] rd,
                     input logic ill, input logic redir, input logic [31:0] rpc);
    vec_t v;
    v.name = name; v.op = op; v.csr = csr; v.src = src; v.x0 = x0; v.pc = pc;
    v.rdata = rdata; v.chk_ra = chk_ra; v.ra = ra; v.wen = wen; v.wa1 = wa1;
    v.wd1 = wd1; v.wa2 = wa2; v.wd2 = wd2; v.rd = rd; v.ill = ill;
    v.redir = redir; v.rpc = rpc;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bif.req_valid  = 1'b0;
    bif.req_op     = 3'd0;
    bif.req_csr    = 12'h000;
    bif.req_src    = 32'h0;
    bif.req_src_x0 = 1'b0;
    bif.req_pc     = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, ".ready"}, {31'b0, bif.req_ready}, 32'd1);
    bif.req_valid  = 1'b1;
    bif.req_op     = v.op;
    bif.req_csr    = v.csr;
    bif.req_src    = v.src;
    bif.req_src_x0 = v.x0;
    bif.req_pc     = v.pc;
    bif.csr_rdata  = v.rdata;
    @(negedge clk);  // READ
    if (v.chk_ra) chk({v.name, ".raddr"}, {20'b0, bif.csr_raddr}, {20'b0, v.ra});
    chk({v.name, ".busy"}, {31'b0, bif.req_ready}, 32'd0);
    // A different request held on the bus while busy must be ignored.
    bif.req_op  = 3'd4;
    bif.req_csr = 12'h123;
    bif.req_src = 32'hFFFF_FFFF;
    bif.req_pc  = 32'hFFFF_FFFC;
    @(negedge clk);  // WRITE
    idle_inputs();
    chk({v.name, ".wen"}, {31'b0, bif.csr_wen}, {31'b0, v.wen});
    chk({v.name, ".waddr2"}, {20'b0, bif.csr_waddr2}, {20'b0, v.wa2});
    if (v.wen) begin
      chk({v.name, ".waddr1"}, {20'b0, bif.csr_waddr1}, {20'b0, v.wa1});
      chk({v.name, ".wdata1"}, bif.csr_wdata1, v.wd1);
      if (v.wa2 != 12'h000) chk({v.name, ".wdata2"}, bif.csr_wdata2, v.wd2);
    end
    @(negedge clk);  // RESP
    chk({v.name, ".resp_valid"}, {31'b0, bif.resp_valid}, 32'd1);
    chk({v.name, ".rd_data"}, bif.resp_rd_data, v.rd);
    chk({v.name, ".illegal"}, {31'b0, bif.resp_illegal}, {31'b0, v.ill});
    chk({v.name, ".redir_valid"}, {31'b0, bif.redirect_valid}, {31'b0, v.redir});
    if (v.redir) chk({v.name, ".redir_pc"}, bif.redirect_pc, v.rpc);
    @(negedge clk);  // back to IDLE
    chk({v.name, ".pulse_end"}, {30'b0, bif.resp_valid, bif.redirect_valid}, 32'd0);
    chk({v.name, ".idle_ready"}, {31'b0, bif.req_ready}, 32'd1);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b0;
    idle_inputs();
    bif.csr_rdata = 32'h0;

    //   name      op   csr     src           x0 pc            rdata       chkra ra  wen wa1    wd1           wa2     wd2    rd            ill redir rpc
    add("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 0, 32'h0, 32'h0, 1, 12'h305, 1, 12'h305, 32'h8000_0100, 12'h000, 32'h0, 32'h0, 0, 0, 32'h0);
    add("rs_mstat", 3'd1, 12'h300, 32'h8, 0, 32'h0, 32'h1800, 1, 12'h300, 1, 12'h300, 32'h1808, 12'h000, 32'h0, 32'h1800, 0, 0, 32'h0);
    add("rs_x0", 3'd1, 12'h300, 32'h8, 1, 32'h0, 32'h1800, 1, 12'h300, 0, 12'h300, 32'h0, 12'h000, 32'h0, 32'h1800, 0, 0, 32'h0);
    add("rc_mstat", 3'd2, 12'h300, 32'h8, 0, 32'h0, 32'h1808, 1, 12'h300, 1, 12'h300, 32'h1800, 12'h000, 32'h0, 32'h1808, 0, 0, 32'h0);
    add("rc_x0", 3'd2, 12'h300, 32'h8, 1, 32'h0, 32'h1808, 1, 12'h300, 0, 12'h300, 32'h0, 12'h000, 32'h0, 32'h1808, 0, 0, 32'h0);
    add("rw_x0", 3'd0, 12'h341, 32'h0, 1, 32'h0, 32'h1234, 1, 12'h341, 1, 12'h341, 32'h0, 12'h000, 32'h0, 32'h1234, 0, 0, 32'h0);
    add("rw_unimpl", 3'd0, 12'h7C0, 32'hA5A5_0F0F, 0, 32'h0, 32'h5555, 1, 12'h7C0, 1, 12'h7C0, 32'hA5A5_0F0F, 12'h000, 32'h0, 32'h5555, 0, 0, 32'h0);
    add("ecall", 3'd3, 12'h7FF, 32'h0, 0, 32'h8000_0040, 32'h8000_0100, 1, 12'h305, 1, 12'h341, 32'h8000_0040, 12'h342, 32'd11, 32'h8000_0100, 0, 1, 32'h8000_0100);
    add("mret", 3'd4, 12'h000, 32'h0, 0, 32'h0, 32'h8000_0040, 1, 12'h341, 0, 12'h000, 32'h0, 12'h000, 32'h0, 32'h8000_0040, 0, 1, 32'h8000_0040);
    add("mret_bump", 3'd4, 12'h000, 32'h0, 0, 32'h0, 32'h8000_0044, 1, 12'h341, 0, 12'h000, 32'h0, 12'h000, 32'h0, 32'h8000_0044, 0, 1, 32'h8000_0044);
`ifdef YSYX_25050148_CSR_ILLEGAL_TRAP_EN
    add("ill6", 3'd6, 12'h300, 32'h0, 0, 32'h8000_0080, 32'hDEAD_BEEF, 1, 12'h305, 1, 12'h341, 32'h8000_0080, 12'h342, 32'd2, 32'hDEAD_BEEF, 1, 1, 32'hDEAD_BEEF);
    add("ill5", 3'd5, 12'h300, 32'h0, 0, 32'h8000_0084, 32'h8000_0200, 1, 12'h305, 1, 12'h341, 32'h8000_0084, 12'h342, 32'd2, 32'h8000_0200, 1, 1, 32'h8000_0200);
    add("ill7", 3'd7, 12'h300, 32'h0, 0, 32'h8000_0088, 32'h8000_0200, 1, 12'h305, 1, 12'h341, 32'h8000_0088, 12'h342, 32'd2, 32'h8000_0200, 1, 1, 32'h8000_0200);
`else
    add("ill6", 3'd6, 12'h300, 32'h0, 0, 32'h8000_0080, 32'hDEAD_BEEF, 0, 12'h000, 0, 12'h000, 32'h0, 12'h000, 32'h0, 32'h0, 1, 0, 32'h0);
    add("ill5", 3'd5, 12'h300, 32'h0, 0, 32'h8000_0084, 32'hDEAD_BEEF, 0, 12'h000, 0, 12'h000, 32'h0, 12'h000, 32'h0, 32'h0, 1, 0, 32'h0);
    add("ill7", 3'd7, 12'h300, 32'h0, 0, 32'h8000_0088, 32'hDEAD_BEEF, 0, 12'h000, 0, 12'h000, 32'h0, 12'h000, 32'h0, 32'h0, 1, 0, 32'h0);
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready", {31'b0, bif.req_ready}, 32'd1);
    chk("rst.wen", {31'b0, bif.csr_wen}, 32'd0);
    chk("rst.redirect", {31'b0, bif.redirect_valid}, 32'd0);
    chk("rst.resp", {31'b0, bif.resp_valid}, 32'd0);
    chk("rst.waddrs", {8'b0, bif.csr_waddr1, bif.csr_waddr2}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Async reset in the WRITE cycle of a CSRRW: write enable must drop at once.
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_op    = 3'd0;
    bif.req_csr   = 12'h305;
    bif.req_src   = 32'h1111_2222;
    bif.csr_rdata = 32'h0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("arst.wen_before", {31'b0, bif.csr_wen}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst.wen_after", {31'b0, bif.csr_wen}, 32'd0);
    chk("arst.idle", {31'b0, bif.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst.no_resp", {30'b0, bif.resp_valid, bif.csr_wen}, 32'd0);
    end

    // Sequencer still works after the mid-sequence reset.
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
